west_feeder: RTL
================

# west_feeder

Row-parallel input stage that sits directly west of the MAC array and drives every row's `in_w`/`inst_w` pair. It buffers row-wide vectors (weights or activations) written by the core controller and replays them under a load or execute command. Each row is delayed by its row index to produce the diagonal skew the systolic tiles expect. Stalls on an empty buffer by inserting idle bubbles, never by corrupting data.

## Interface
Parameters:
- `row`, 8, number of array rows driven (≥2)
- `bw`, 4, per-row data width (matches tile `bw`)
- `depth`, 16, buffer entries, power of two
- `len_bw`, 8, width of the command length field

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `wr`  in  1  push `in` into buffer when `full`=0
- `in`  in  row*bw  row vector; row r occupies bits [r*bw +: bw]
- `full`  out  1  buffer holds `depth` entries
- `empty`  out  1  buffer holds 0 entries
- `cmd_valid`  in  1  command request
- `cmd_op`  in  2  2'b01 load, 2'b10 execute; other codes ignored
- `cmd_len`  in  len_bw  number of vectors to issue
- `cmd_ready`  out  1  high only in IDLE
- `busy`  out  1  high whenever state ≠ IDLE
- `out`  out  row*bw  per-row data to tile `in_w`, row r at [r*bw +: bw]
- `inst_w`  out  2*row  per-row instruction, row r at [2r +: 2]
- `err`  out  1  sticky overflow flag (see Configuration)

## Operation
- Buffer: circular FIFO, `depth` entries of row*bw bits, ptr width log2(depth)+1 (wrap bit distinguishes full/empty).
- Write accepted iff `wr` & !`full`. Write while `full` dropped, no state change; same-cycle pop does not rescue it (`full` uses pre-edge occupancy).
- Write and pop on the same edge with 0 < occupancy < depth: occupancy unchanged. No bypass: a vector written at edge E is poppable no earlier than edge E+1.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: `cmd_ready`=1. Handshake `cmd_valid`&`cmd_ready` with legal op and `cmd_len`>0 → latch op, remaining=`cmd_len`, go RUN. `cmd_len`=0 or illegal op: accepted, stay IDLE, no output activity.
  - RUN: each cycle, if !`empty`: pop, drive stage-0 with {data, op}, remaining−1; else drive stage-0 {0, 2'b00} (bubble), no pop, remaining held. Pop with remaining=1 → DRAIN.
  - DRAIN: counts `row` cycles, then IDLE.
- Skew: row r passes through r+1 registers from pop point, so row 0 has 1 register, row `row`−1 has `row`. Data and instruction of a row travel together.
- Bubbles propagate identically, giving tiles inst 2'b00 and holding their state.
- Reset at any point: FIFO pointers, skew registers, FSM, counters, `err` cleared on that edge. In-flight vectors are discarded.

## Timing
- Reset values: `out`=0, `inst_w`=0, `full`=0, `empty`=1, `cmd_ready`=1, `busy`=0, `err`=0.
- Command accepted at edge E → RUN during cycle E..E+1; first pop at edge E+1 if non-empty.
- Pop at edge t → row r `out`/`inst_w` valid in the cycle after edge t+r.
- Last pop at edge t → DRAIN covers edges t+1..t+row. IDLE, `cmd_ready`=1 after edge t+row. All rows have emitted the last vector by then.
- `full`, `empty`, `busy`, `cmd_ready` are registered-state decodes with no combinational path from inputs.

## Configuration
- `WEST_FEEDER_ERR_EN` defined: `err` is set on any write attempt while `full`, stays set until `reset`.
- Not defined: `err` tied 0, no detection logic.

## Structure
- Shared package `feeder_pkg`: state encoding (IDLE/RUN/DRAIN), instruction constants INST_IDLE=2'b00, INST_LOAD=2'b01, INST_EXEC=2'b10.
- One sub-module `skew_delay`, parameterised by width and stage count, instantiated once per row for {data, inst}. FIFO and FSM live in the top.

## Test plan
- Reset → all outputs at the listed reset values. Push one vector and assert reset on the same edge → `empty`=1, nothing emitted.
- Push vectors A,B,C, then command load len 3 → row 0 `inst_w`=01 with A,B,C on 3 consecutive cycles. Row 7 is identical 7 cycles later. `cmd_ready` returns `row` cycles after the last pop.
- Push 2 vectors, command execute len 4, push 2 more 5 cycles later → row 0 shows 10,10, then 00 bubbles, then 10,10. No vector lost or duplicated.
- Write 16 vectors → `full`=1. 17th write dropped, and the read-back order is 1..16. With macro `err`=1; without it `err`=0.
- Command with `cmd_len`=0 or `cmd_op`=2'b11 → `busy` stays 0, `inst_w` stays 0, buffer untouched.
- Reset asserted mid-RUN with 3 vectors remaining → next cycle IDLE, `inst_w`=0 on all rows, `empty`=1.

Source files
------------

// File: rtl/feeder_pkg.sv
// Shared definitions for the west feeder: FSM state encoding and the
// per-row instruction codes presented to the tiles.
package feeder_pkg;

    // Command FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Instruction codes carried alongside each row's data.
    localparam logic [1:0] INST_IDLE = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

    // Only load and execute start a run; every other op code is a no-op.
    function automatic logic is_legal_op(input logic [1:0] op);
        return (op == INST_LOAD) || (op == INST_EXEC);
    endfunction

endpackage

// File: rtl/skew_delay.sv
// Fixed-length register chain. Used once per row to carry {data, inst}
// through (row index + 1) stages, which produces the diagonal skew.
module skew_delay #(
    parameter int width  = 6,
    parameter int stages = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic [width-1:0] pipe [stages];

    // Shift the chain every cycle; reset flushes everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < stages; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < stages; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign q = pipe[stages-1];

endmodule

// File: rtl/west_feeder.sv
// West feeder: buffers row-wide vectors in a circular FIFO and replays them
// into the MAC array under a load/execute command, skewing row r by r+1
// registers. An empty buffer during a run produces idle bubbles (inst 00).
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high exactly while the FSM is IDLE.
// A buffer write transfers on a rising edge where wr is high and full is low.
//
// Optional feature: define WEST_FEEDER_ERR_EN to make err a sticky flag
// raised by any write attempt while full. Without it err is constant 0.
module west_feeder
    import feeder_pkg::*;
#(
    parameter int row    = 8,
    parameter int bw     = 4,
    parameter int depth  = 16,
    parameter int len_bw = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr,
    input  logic [row*bw-1:0]   in,
    output logic                full,
    output logic                empty,
    input  logic                cmd_valid,
    input  logic [1:0]          cmd_op,
    input  logic [len_bw-1:0]   cmd_len,
    output logic                cmd_ready,
    output logic                busy,
    output logic [row*bw-1:0]   out,
    output logic [2*row-1:0]    inst_w,
    output logic                err
);

    localparam int aw = $clog2(depth);
    localparam int pw = aw + 1;
    localparam int cw = $clog2(row + 1);

    logic [row*bw-1:0] mem [depth];
    logic [pw-1:0]     wr_ptr;
    logic [pw-1:0]     rd_ptr;
    logic              push;
    logic              pop;

    state_t            state;
    logic [1:0]        op_q;
    logic [len_bw-1:0] remaining;
    logic [cw-1:0]     drain_cnt;

    logic [row*bw-1:0] stage0_data;
    logic [1:0]        stage0_inst;
    logic [bw+1:0]     skew_q [row];

    // Occupancy flags decode the pointers only; the extra wrap bit separates full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
    assign push  = wr && !full;
    assign pop   = (state == RUN) && !empty;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Buffer storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr[aw-1:0]] <= in;
        end
    end

    // FIFO pointers advance independently on accepted writes and pops.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Command FSM: accept in IDLE, pop in RUN until the count hits zero, then let the skew drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= INST_IDLE;
            remaining <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && is_legal_op(cmd_op) && (cmd_len != '0)) begin
                        op_q      <= cmd_op;
                        remaining <= cmd_len;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (pop) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == len_bw'(1)) begin
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == cw'(row - 1)) begin
                        state <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pop point: a popped vector with the latched op, or a zero bubble when nothing pops.
    always_comb begin
        stage0_data = '0;
        stage0_inst = INST_IDLE;
        if (pop) begin
            stage0_data = mem[rd_ptr[aw-1:0]];
            stage0_inst = op_q;
        end
    end

    for (genvar r = 0; r < row; r++) begin : g_row
        skew_delay #(
            .width  (bw + 2),
            .stages (r + 1)
        ) u_skew (
            .clk   (clk),
            .reset (reset),
            .d     ({stage0_data[r*bw +: bw], stage0_inst}),
            .q     (skew_q[r])
        );
    end

    // Reassemble the per-row chain outputs into the flat tile-facing buses.
    always_comb begin
        out    = '0;
        inst_w = '0;
        for (int r = 0; r < row; r++) begin
            out[r*bw +: bw]  = skew_q[r][bw+1:2];
            inst_w[2*r +: 2] = skew_q[r][1:0];
        end
    end

`ifdef WEST_FEEDER_ERR_EN
    // Sticky overflow flag: any write attempt against a full buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (wr && full) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
